// File: rtl/eq2_share_arb.sv
// Round-robin sequencer sharing one registered 2-bit equality comparator among NREQ requesters.
// Optional saturating mismatch counter enabled by defining EQ2_ARB_MISMATCH_CNT_EN.
//
// state | meaning
// IDLE  | waiting for any req; the grant edge picks the winner and latches its operands
// CMP   | one cycle, gnt high, comparator evaluates the captured operands
// RSP   | response held on rsp_* until rsp_ready
module eq2_share_arb #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ),
   parameter int CW   = 8
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] a_in,
   input  logic [2*NREQ-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IW-1:0]     rsp_id,
   output logic              rsp_z
`ifdef EQ2_ARB_MISMATCH_CNT_EN
   ,
   output logic [CW-1:0]     mismatch_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RSP  = 2'd2
   } state_t;

   generate
      if (NREQ < 2 || NREQ > 8 || IW != $clog2(NREQ) || CW < 1) begin : g_bad_param
         $error("eq2_share_arb: illegal parameter set");
      end
   endgenerate

   state_t          state_q;
   state_t          state_nxt;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win_id;
   logic [IW-1:0]   win_nxt;
   logic            win_found;
   logic [1:0]      op_a;
   logic [1:0]      op_b;
   logic            any_req;
   logic            ops_eq;

   assign any_req = |req;
   assign ops_eq  = (op_a == op_b);

   // Search starts one past the last winner so a held request cannot starve others.
   always_comb begin
      win_found = 1'b0;
      win_nxt   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!win_found && req[(int'(ptr) + i) % NREQ]) begin
            win_found = 1'b1;
            win_nxt   = IW'((int'(ptr) + i) % NREQ);
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (any_req) state_nxt = CMP;
         CMP:     state_nxt = RSP;
         RSP:     if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         gnt       <= '0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_z     <= 1'b0;
         ptr       <= IW'(NREQ - 1);
         win_id    <= '0;
         op_a      <= '0;
         op_b      <= '0;
      end else begin
         gnt  <= '0;
         busy <= (state_nxt != IDLE);
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  op_a   <= a_in[2*int'(win_nxt) +: 2];
                  op_b   <= b_in[2*int'(win_nxt) +: 2];
                  win_id <= win_nxt;
                  ptr    <= win_nxt;
                  gnt    <= NREQ'(1) << win_nxt;
               end
            end
            CMP: begin
               rsp_z     <= ops_eq;
               rsp_id    <= win_id;
               rsp_valid <= 1'b1;
            end
            RSP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef EQ2_ARB_MISMATCH_CNT_EN
   // Counts on the same edge that publishes the result; sticks at all-ones.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         mismatch_cnt <= '0;
      end else if (state_q == CMP && !ops_eq && mismatch_cnt != {CW{1'b1}}) begin
         mismatch_cnt <= mismatch_cnt + CW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_eq2_share_arb.sv
// Directed bench for eq2_share_arb: reset, single request, round-robin order,
// backpressure, asynchronous reset mid-response and (with the macro) the mismatch counter.
module tb_eq2_share_arb;

   localparam int NREQ = 4;
   localparam int IW   = 2;
   localparam int CW   = 2;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] a_in;
   logic [2*NREQ-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic              rsp_z;
`ifdef EQ2_ARB_MISMATCH_CNT_EN
   logic [CW-1:0]     mismatch_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   eq2_share_arb #(.NREQ(NREQ), .CW(CW)) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_z     (rsp_z)
`ifdef EQ2_ARB_MISMATCH_CNT_EN
      ,
      .mismatch_cnt (mismatch_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};

      // Reset with random activity on the inputs
      aresetn   = 1'b0;
      req       = 4'($urandom);
      a_in      = 8'($urandom);
      b_in      = 8'($urandom);
      rsp_ready = 1'($urandom);
      repeat (3) tick();
      req = 4'b1111;
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_z", rsp_z, 0);
`ifdef EQ2_ARB_MISMATCH_CNT_EN
      chk("rst_cnt", mismatch_cnt, 0);
`endif

      // Round-robin: a=b=i, except requester 3 with a=11 b=01
      @(negedge clk);
      req       = 4'b1111;
      a_in      = 8'b11_10_01_00;
      b_in      = 8'b01_10_01_00;
      rsp_ready = 1'b1;
      aresetn   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_gnt", gnt, 32'd1 << order[k]);
         chk("rr_busy", busy, 1);
         tick();
         chk("rr_gnt_drop", gnt, 0);
         chk("rr_valid", rsp_valid, 1);
         chk("rr_id", rsp_id, order[k]);
         chk("rr_z", rsp_z, (order[k] == 3) ? 0 : 1);
         tick();
         chk("rr_retire", rsp_valid, 0);
         chk("rr_idle", busy, 0);
      end
      req = 4'b0000;
      tick();
      chk("idle_no_gnt", gnt, 0);

      // Single request from requester 2
      req  = 4'b0100;
      a_in = 8'b00_10_00_00;
      b_in = 8'b00_10_00_00;
      tick();
      chk("single_gnt", gnt, 4'b0100);
      chk("single_busy1", busy, 1);
      req = 4'b0000;
      tick();
      chk("single_gnt_drop", gnt, 0);
      chk("single_valid", rsp_valid, 1);
      chk("single_id", rsp_id, 2);
      chk("single_z", rsp_z, 1);
      chk("single_busy2", busy, 1);
      tick();
      chk("single_retire", rsp_valid, 0);
      chk("single_busy_end", busy, 0);

      // Backpressure: ptr=2, so requester 0 wins among 0011
      req       = 4'b0011;
      a_in      = 8'b00_00_01_01;
      b_in      = 8'b00_00_01_10;
      rsp_ready = 1'b0;
      tick();
      chk("bp_gnt", gnt, 4'b0001);
      a_in = 8'b00_00_01_10;
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id0", rsp_id, 0);
      chk("bp_z0", rsp_z, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_id", rsp_id, 0);
         chk("bp_hold_z", rsp_z, 0);
         chk("bp_no_gnt", gnt, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_retire", rsp_valid, 0);
      tick();
      chk("bp_next_gnt", gnt, 4'b0010);
      req = 4'b0000;
      tick();
      chk("bp_id1", rsp_id, 1);
      chk("bp_z1", rsp_z, 1);
      tick();
      chk("bp_retire1", rsp_valid, 0);

      // Asynchronous reset while a response from requester 2 is pending
      req       = 4'b0100;
      a_in      = 8'b00_11_00_00;
      b_in      = 8'b00_11_00_00;
      rsp_ready = 1'b0;
      tick();
      chk("ar_gnt", gnt, 4'b0100);
      req = 4'b0000;
      tick();
      chk("ar_valid_pre", rsp_valid, 1);
      #3;
      aresetn = 1'b0;
      #1;
      chk("ar_valid_drop", rsp_valid, 0);
      chk("ar_busy_drop", busy, 0);
      chk("ar_id_clr", rsp_id, 0);
      rsp_ready = 1'b1;
      tick();
      @(negedge clk);
      aresetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ar_no_rsp", rsp_valid, 0);
         chk("ar_no_gnt", gnt, 0);
      end
`ifdef EQ2_ARB_MISMATCH_CNT_EN
      chk("ar_cnt_clr", mismatch_cnt, 0);
`endif

      // ptr back at NREQ-1: requester 0 wins; then 5 unequal and 1 equal transaction
      req  = 4'b1111;
      a_in = 8'b00_00_00_00;
      b_in = 8'b00_00_00_11;
      for (int k = 0; k < 6; k++) begin
         if (k == 5) b_in = 8'b00_00_00_00;
         tick();
         chk("cnt_gnt", gnt, 4'b0001);
         req = 4'b0001;
         tick();
         chk("cnt_z", rsp_z, (k == 5) ? 1 : 0);
`ifdef EQ2_ARB_MISMATCH_CNT_EN
         chk("cnt_val", mismatch_cnt, (k >= 2) ? 3 : k + 1);
`endif
         tick();
         chk("cnt_retire", rsp_valid, 0);
      end
      req = 4'b0000;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/eq2_share_arb.md
# eq2_share_arb

Round-robin arbiter and sequencer that time-shares one registered 2-bit equality comparator (z = A==B) among NREQ requesters. Each requester presents a 2-bit operand pair with a request. The block grants one requester at a time, captures its operands, performs the comparison and returns the result over a valid/ready response channel tagged with the requester ID. It sits between the comparator datapath and the client blocks that need equality checks.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- IW, $clog2(NREQ), requester ID width; derived, must not be overridden.
- CW, 8, mismatch counter width; used only with EQ2_ARB_MISMATCH_CNT_EN.

- clk  in  1  single clock; all state updates on posedge.
- aresetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- a_in  in  2*NREQ  operand A; requester i drives a_in[2i+1:2i].
- b_in  in  2*NREQ  operand B; requester i drives b_in[2i+1:2i].
- gnt  out  NREQ  one-hot grant, registered, one-cycle pulse.
- busy  out  1  high whenever the state is not IDLE.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IW  ID of the requester this response belongs to.
- rsp_z  out  1  1 = operands equal, 0 = unequal.
- mismatch_cnt  out  CW  saturating count of unequal results; present only with the macro.

## Operation
- FSM states: IDLE, CMP, RSP. Reset state is IDLE.
- IDLE: if req != 0 at a posedge, that edge does all of the following:
  - Select the winner round-robin, starting at (ptr+1) mod NREQ and searching upward with wrap.
  - Latch the winner's a/b slices into operand registers.
  - Register the winner ID.
  - Set gnt[winner]=1, set ptr=winner, and go to CMP.
  - If req == 0, stay in IDLE.
- CMP: lasts exactly one cycle, with gnt high during it. At the next edge:
  - gnt goes to 0.
  - rsp_z takes the value (opA == opB).
  - rsp_id takes the registered winner ID.
  - rsp_valid goes to 1 and the state goes to RSP.
  - req is ignored in CMP and RSP.
- RSP: rsp_valid, rsp_id and rsp_z hold stable until an edge where rsp_ready=1. At that edge rsp_valid goes to 0 and the state goes to IDLE.
- Requester obligations:
  - Hold req and operands until gnt is seen.
  - Deassert req the cycle after gnt, or keep it high to request again.
  - Operands are sampled only at the grant edge; later changes have no effect on the result.
- ptr changes only on a grant. Reset value is NREQ-1, so requester 0 has first priority after reset.
- A requester that keeps req high is re-granted only after every other pending requester has been served once.

## Timing
- Reset values: gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_z=0, ptr=NREQ-1, operand registers=0, mismatch_cnt=0.
- Reset is asynchronous: it takes effect immediately, at any state, without waiting for a clock edge.
  - Any in-flight transaction is dropped; no response is ever issued for it.
  - The requester must re-request after reset.
- Latency, with the request sampled at edge E0:
  - gnt is high during [E0,E1).
  - rsp_valid is high from E1.
  - If rsp_ready=1 at E2, the earliest next grant edge is E3.
- Minimum grant spacing is 3 cycles.
- gnt, busy, rsp_* and mismatch_cnt are all driven from registers; there is no combinational path from req or rsp_ready to any output.

## Configuration
- EQ2_ARB_MISMATCH_CNT_EN defined:
  - The mismatch_cnt port and its CW-bit register are present.
  - The counter increments on the CMP→RSP edge whenever the captured rsp_z=0.
  - It saturates at 2^CW-1 and clears only on reset.
- EQ2_ARB_MISMATCH_CNT_EN undefined: the port and the register do not exist; all other behaviour is identical.

## Test plan
- Reset: drive aresetn=0 with random inputs → all outputs 0; after release, the first grant with req=4'b1111 goes to requester 0.
- Single request: req=4'b0100, a_in[5:4]=2'b10, b_in[5:4]=2'b10, rsp_ready=1 → gnt=4'b0100 for one cycle, then rsp_valid=1, rsp_id=2, rsp_z=1 for one cycle; busy high for 2 cycles.
- Round-robin: req=4'b1111 held, rsp_ready=1, requester i using a=b=i except requester 3 using a=2'b11, b=2'b01 → grant order 0,1,2,3,0 spaced 3 cycles apart; rsp_z sequence 1,1,1,0.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_id/rsp_z stable, no gnt despite req=4'b0011; rsp_ready=1 → response retires, next grant 1 cycle later.
- Counter (macro defined, CW=2): 5 unequal transactions (a=2'b00, b=2'b11) → mismatch_cnt 1,2,3,3,3; an equal transaction leaves it at 3.
- Async reset in RSP: assert aresetn=0 mid-cycle → rsp_valid drops before the next edge and ptr returns to NREQ-1; no response is issued after release.
